// File: rtl/cu_pkg.sv
// Shared types and constants for the ARM-subset multicycle control unit:
// FSM states, ALU opcodes, datapath mux selects and condition codes.
package cu_pkg;

    typedef enum logic [3:0] {
        RST = 4'd0,
        F0  = 4'd1,
        F1  = 4'd2,
        DEC = 4'd3,
        DP  = 4'd4,
        LSA = 4'd5,
        LSD = 4'd6,
        LSM = 4'd7,
        LSW = 4'd8,
        BL0 = 4'd9,
        BR  = 4'd10
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0010;

    // port-A register select
    localparam logic [1:0] MA_RN = 2'd0;
    localparam logic [1:0] MA_RD = 2'd1;
    localparam logic [1:0] MA_PC = 2'd2;

    // ALU B source
    localparam logic [1:0] MB_RM   = 2'd0;
    localparam logic [1:0] MB_IMM  = 2'd1;
    localparam logic [1:0] MB_OFS  = 2'd2;
    localparam logic [1:0] MB_FOUR = 2'd3;

    // write-register select
    localparam logic [1:0] MC_RD = 2'd0;
    localparam logic [1:0] MC_RN = 2'd1;
    localparam logic [1:0] MC_LR = 2'd2;
    localparam logic [1:0] MC_PC = 2'd3;

    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_MI = 4'b0100;
    localparam logic [3:0] CC_PL = 4'b0101;
    localparam logic [3:0] CC_VS = 4'b0110;
    localparam logic [3:0] CC_VC = 4'b0111;
    localparam logic [3:0] CC_HI = 4'b1000;
    localparam logic [3:0] CC_LS = 4'b1001;
    localparam logic [3:0] CC_GE = 4'b1010;
    localparam logic [3:0] CC_LT = 4'b1011;
    localparam logic [3:0] CC_GT = 4'b1100;
    localparam logic [3:0] CC_LE = 4'b1101;
    localparam logic [3:0] CC_AL = 4'b1110;
    localparam logic [3:0] CC_NV = 4'b1111;

endpackage

// File: rtl/cu_cond_eval.sv
// ARM condition-field evaluator: pass=1 when cond holds for flags {N,Z,C,V}.
// The NV encoding never passes; the sequencer treats it as undefined.
module cu_cond_eval
    import cu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        pass = 1'b0;
        case (cond)
            CC_EQ: pass = z;
            CC_NE: pass = !z;
            CC_CS: pass = c;
            CC_CC: pass = !c;
            CC_MI: pass = n;
            CC_PL: pass = !n;
            CC_VS: pass = v;
            CC_VC: pass = !v;
            CC_HI: pass = c && !z;
            CC_LS: pass = !c || z;
            CC_GE: pass = (n == v);
            CC_LT: pass = (n != v);
            CC_GT: pass = !z && (n == v);
            CC_LE: pass = z || (n != v);
            CC_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cu_microseq.sv
// Multicycle Moore control sequencer for the ARM-subset datapath (DP, LDR/STR imm, B/BL).
// Define CU_MOC_TIMEOUT_EN to abort memory waits after MOC_TIMEOUT cycles without moc.
module cu_microseq
    import cu_pkg::*;
#(
    parameter int MOC_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic [3:0]  flags,
    input  logic        moc,
    output logic [1:0]  ma,
    output logic [1:0]  mb,
    output logic [1:0]  mc,
    output logic        md,
    output logic        me,
    output logic        mf,
    output logic        mg,
    output logic        mh,
    output logic [3:0]  op,
    output logic        rf_ld,
    output logic        ir_ld,
    output logic        mar_ld,
    output logic        mdr_ld,
    output logic        flag_ld,
    output logic        mov,
    output logic        rw,
    output logic        und,
    output logic        abort,
    output logic [3:0]  state
);

    state_t cur, nxt;
    logic   cond_pass;
    logic   expired;

    assign state = cur;

    cu_cond_eval u_cond (
        .cond  (ir[31:28]),
        .flags (flags),
        .pass  (cond_pass)
    );

`ifdef CU_MOC_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // moc in the expiry cycle still completes the access
    assign expired = (cur == F1 || cur == LSM) && !moc && (wait_cnt == 8'(MOC_TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset)
            wait_cnt <= '0;
        else if (nxt != cur)
            wait_cnt <= '0;
        else if (!moc)
            wait_cnt <= wait_cnt + 8'd1;
    end
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(MOC_TIMEOUT);
    assign expired = 1'b0;
`endif

    logic unused_ir;
    assign unused_ir = ^{ir[22:21], ir[19:0]};

    always_ff @(posedge clk) begin
        if (reset)
            cur <= RST;
        else
            cur <= nxt;
    end

    always_comb begin
        nxt     = cur;
        ma      = MA_RN;
        mb      = MB_RM;
        mc      = MC_RD;
        md      = 1'b0;
        me      = 1'b0;
        mf      = 1'b0;
        mg      = 1'b0;
        mh      = 1'b0;
        op      = 4'b0000;
        rf_ld   = 1'b0;
        ir_ld   = 1'b0;
        mar_ld  = 1'b0;
        mdr_ld  = 1'b0;
        flag_ld = 1'b0;
        mov     = 1'b0;
        rw      = 1'b0;
        und     = 1'b0;
        abort   = 1'b0;

        case (cur)
            RST: nxt = F0;
            F0: begin
                mg     = 1'b1;
                mar_ld = 1'b1;
                ma     = MA_PC;
                mb     = MB_FOUR;
                md     = 1'b1;
                op     = ALU_ADD;
                mc     = MC_PC;
                rf_ld  = 1'b1;
                nxt    = F1;
            end
            F1: begin
                if (expired) begin
                    abort = 1'b1;
                    nxt   = F0;
                end else begin
                    mov = 1'b1;
                    rw  = 1'b1;
                    if (moc) begin
                        ir_ld = 1'b1;
                        nxt   = DEC;
                    end
                end
            end
            DEC: begin
                nxt = F0;
                if (ir[31:28] == CC_NV)
                    und = 1'b1;
                else if (cond_pass) begin
                    case (ir[27:25])
                        3'b000, 3'b001: nxt = DP;
                        3'b010, 3'b011: nxt = LSA;
                        3'b101:         nxt = ir[24] ? BL0 : BR;
                        default:        und = 1'b1;
                    endcase
                end
            end
            DP: begin
                mb      = ir[25] ? MB_IMM : MB_RM;
                flag_ld = ir[20];
                // TST/TEQ/CMP/CMN only update flags
                rf_ld   = (ir[24:23] != 2'b10);
                nxt     = F0;
            end
            LSA: begin
                mb     = MB_OFS;
                md     = 1'b1;
                op     = ir[23] ? ALU_ADD : ALU_SUB;
                mar_ld = 1'b1;
                nxt    = ir[20] ? LSM : LSD;
            end
            LSD: begin
                ma     = MA_RD;
                mf     = 1'b1;
                mdr_ld = 1'b1;
                nxt    = LSM;
            end
            LSM: begin
                if (expired) begin
                    abort = 1'b1;
                    nxt   = F0;
                end else begin
                    mov = 1'b1;
                    rw  = ir[20];
                    if (moc) begin
                        if (ir[20]) begin
                            mdr_ld = 1'b1;
                            nxt    = LSW;
                        end else
                            nxt = F0;
                    end
                end
            end
            LSW: begin
                mh    = 1'b1;
                rf_ld = 1'b1;
                nxt   = F0;
            end
            BL0: begin
                ma    = MA_PC;
                me    = 1'b1;
                md    = 1'b1;
                op    = ALU_ADD;
                mc    = MC_LR;
                rf_ld = 1'b1;
                nxt   = BR;
            end
            BR: begin
                ma    = MA_PC;
                mb    = MB_OFS;
                md    = 1'b1;
                op    = ALU_ADD;
                mc    = MC_PC;
                rf_ld = 1'b1;
                nxt   = F0;
            end
            default: nxt = RST;
        endcase
    end

endmodule

// File: tb/tb_cu_microseq.sv
// Directed table-driven bench for cu_microseq: per-cycle inputs and hand-derived state/controls.
module tb_cu_microseq;
    import cu_pkg::*;

    logic        clk, reset, moc;
    logic [31:0] ir;
    logic [3:0]  flags;
    logic [1:0]  ma, mb, mc;
    logic        md, me, mf, mg, mh;
    logic [3:0]  op, state;
    logic        rf_ld, ir_ld, mar_ld, mdr_ld, flag_ld, mov, rw, und, abort;
    logic [23:0] got;

    int total = 0;
    int bad   = 0;

    cu_microseq #(.MOC_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .ir(ir), .flags(flags), .moc(moc),
        .ma(ma), .mb(mb), .mc(mc), .md(md), .me(me), .mf(mf), .mg(mg), .mh(mh),
        .op(op), .rf_ld(rf_ld), .ir_ld(ir_ld), .mar_ld(mar_ld), .mdr_ld(mdr_ld),
        .flag_ld(flag_ld), .mov(mov), .rw(rw), .und(und), .abort(abort), .state(state)
    );

    assign got = {ma, mb, mc, md, me, mf, mg, mh, op, rf_ld, ir_ld, mar_ld, mdr_ld,
                  flag_ld, mov, rw, und, abort};

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] ir;
        logic [3:0]  flags;
        logic        moc;
        state_t      st;
        logic [23:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [23:0] pk(
        input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
        input logic d, input logic e, input logic f, input logic g, input logic h,
        input logic [3:0] o, input logic rf, input logic irl, input logic mar,
        input logic mdr, input logic fl, input logic mv, input logic r,
        input logic u, input logic ab);
        return {a, b, c, d, e, f, g, h, o, rf, irl, mar, mdr, fl, mv, r, u, ab};
    endfunction

    task automatic add(input logic r, input logic [31:0] i, input logic [3:0] f,
                       input logic m, input state_t s, input logic [23:0] e);
        vec_t v;
        v.rst = r; v.ir = i; v.flags = f; v.moc = m; v.st = s; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic step(input logic r, input logic [31:0] i, input logic [3:0] f,
                        input logic m, input state_t es, input logic [23:0] ev,
                        input string nm);
        @(negedge clk);
        reset = r; ir = i; flags = f; moc = m;
        #1;
        total++;
        if (state !== 4'(es)) begin
            bad++;
            $display("FAIL %s state got=%0d want=%0d", nm, state, es);
        end
        total++;
        if (got !== ev) begin
            bad++;
            $display("FAIL %s ctrl got=%h want=%h", nm, got, ev);
        end
    endtask

    localparam logic [31:0] I_ADD  = 32'hE0812003;
    localparam logic [31:0] I_BEQ  = 32'h0A000004;
    localparam logic [31:0] I_BL   = 32'hEB000010;
    localparam logic [31:0] I_LDR  = 32'hE5912004;
    localparam logic [31:0] I_STR  = 32'hE5012004;
    localparam logic [31:0] I_CMPI = 32'hE3530004;
    localparam logic [31:0] I_UNDC = 32'hEC000000;
    localparam logic [31:0] I_NV   = 32'hF0812003;

    logic [23:0] V0, VF0, VF1, VF1M, VUND, VDPA, VDPC, VBR, VBL0;
    logic [23:0] VLSAA, VLSAS, VLSD, VLM, VLMM, VLSW, VSM, VAB;

    initial begin
        clk = 0; reset = 1; ir = '0; flags = '0; moc = 0;

        V0    = '0;
        VF0   = pk(2, 3, 3, 1, 0, 0, 1, 0, 4'b0100, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        VF1   = pk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        VF1M  = pk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        VUND  = pk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        VDPA  = pk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        VDPC  = pk(0, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        VBR   = pk(2, 2, 3, 1, 0, 0, 0, 0, 4'b0100, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        VBL0  = pk(2, 0, 2, 1, 1, 0, 0, 0, 4'b0100, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        VLSAA = pk(0, 2, 0, 1, 0, 0, 0, 0, 4'b0100, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        VLSAS = pk(0, 2, 0, 1, 0, 0, 0, 0, 4'b0010, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        VLSD  = pk(1, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        VLM   = pk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        VLMM  = pk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        VLSW  = pk(0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        VSM   = pk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        VAB   = pk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // reset, release, ADD with two wait cycles; moc in F0 is ignored
        add(1, I_ADD, 4'b0000, 0, RST, V0);
        add(0, I_ADD, 4'b0000, 0, RST, V0);
        add(0, I_ADD, 4'b0000, 1, F0,  VF0);
        add(0, I_ADD, 4'b0000, 0, F1,  VF1);
        add(0, I_ADD, 4'b0000, 0, F1,  VF1);
        add(0, I_ADD, 4'b0000, 1, F1,  VF1M);
        add(0, I_ADD, 4'b0000, 0, DEC, V0);
        add(0, I_ADD, 4'b0000, 0, DP,  VDPA);
        // BEQ not taken (Z=0), then taken (Z=1)
        add(0, I_BEQ, 4'b0000, 0, F0,  VF0);
        add(0, I_BEQ, 4'b0000, 1, F1,  VF1M);
        add(0, I_BEQ, 4'b0000, 0, DEC, V0);
        add(0, I_BEQ, 4'b0100, 0, F0,  VF0);
        add(0, I_BEQ, 4'b0100, 1, F1,  VF1M);
        add(0, I_BEQ, 4'b0100, 0, DEC, V0);
        add(0, I_BEQ, 4'b0100, 0, BR,  VBR);
        // BL
        add(0, I_BL,  4'b0000, 0, F0,  VF0);
        add(0, I_BL,  4'b0000, 1, F1,  VF1M);
        add(0, I_BL,  4'b0000, 0, DEC, V0);
        add(0, I_BL,  4'b0000, 0, BL0, VBL0);
        add(0, I_BL,  4'b0000, 0, BR,  VBR);
        // LDR with one memory wait
        add(0, I_LDR, 4'b0000, 0, F0,  VF0);
        add(0, I_LDR, 4'b0000, 1, F1,  VF1M);
        add(0, I_LDR, 4'b0000, 0, DEC, V0);
        add(0, I_LDR, 4'b0000, 0, LSA, VLSAA);
        add(0, I_LDR, 4'b0000, 0, LSM, VLM);
        add(0, I_LDR, 4'b0000, 1, LSM, VLMM);
        add(0, I_LDR, 4'b0000, 0, LSW, VLSW);
        // STR, zero-wait completion
        add(0, I_STR, 4'b0000, 0, F0,  VF0);
        add(0, I_STR, 4'b0000, 1, F1,  VF1M);
        add(0, I_STR, 4'b0000, 0, DEC, V0);
        add(0, I_STR, 4'b0000, 0, LSA, VLSAS);
        add(0, I_STR, 4'b0000, 0, LSD, VLSD);
        add(0, I_STR, 4'b0000, 1, LSM, VSM);
        // CMP immediate: flags only, no register write
        add(0, I_CMPI, 4'b0000, 0, F0,  VF0);
        add(0, I_CMPI, 4'b0000, 1, F1,  VF1M);
        add(0, I_CMPI, 4'b0000, 0, DEC, V0);
        add(0, I_CMPI, 4'b0000, 0, DP,  VDPC);
        // undefined class, then cond=1111
        add(0, I_UNDC, 4'b0000, 0, F0,  VF0);
        add(0, I_UNDC, 4'b0000, 1, F1,  VF1M);
        add(0, I_UNDC, 4'b0000, 0, DEC, VUND);
        add(0, I_NV,   4'b0000, 0, F0,  VF0);
        add(0, I_NV,   4'b0000, 1, F1,  VF1M);
        add(0, I_NV,   4'b0000, 0, DEC, VUND);
        // reset while waiting in LSM
        add(0, I_LDR, 4'b0000, 0, F0,  VF0);
        add(0, I_LDR, 4'b0000, 1, F1,  VF1M);
        add(0, I_LDR, 4'b0000, 0, DEC, V0);
        add(0, I_LDR, 4'b0000, 0, LSA, VLSAA);
        add(1, I_LDR, 4'b0000, 0, LSM, VLM);
        add(0, I_LDR, 4'b0000, 0, RST, V0);
        add(0, I_LDR, 4'b0000, 0, F0,  VF0);

        repeat (2) @(posedge clk);
        for (int k = 0; k < tbl.size(); k++)
            step(tbl[k].rst, tbl[k].ir, tbl[k].flags, tbl[k].moc, tbl[k].st, tbl[k].exp,
                 $sformatf("row%0d", k));

`ifdef CU_MOC_TIMEOUT_EN
        // no moc: four wait cycles, then abort pulse and back to F0
        for (int k = 0; k < 4; k++) step(0, I_LDR, 4'b0000, 0, F1, VF1, "to_wait");
        step(0, I_LDR, 4'b0000, 0, F1, VAB, "to_abort");
        step(0, I_LDR, 4'b0000, 0, F0, VF0, "to_refetch");
        // moc arriving in the expiry cycle beats the timeout
        for (int k = 0; k < 4; k++) step(0, I_LDR, 4'b0000, 0, F1, VF1, "to_wait2");
        step(0, I_LDR, 4'b0000, 1, F1, VF1M, "to_moc_wins");
        step(0, I_LDR, 4'b0000, 0, DEC, V0, "to_dec");
`else
        // without the timeout the fetch waits indefinitely
        for (int k = 0; k < 12; k++) step(0, I_LDR, 4'b0000, 0, F1, VF1, "long_wait");
        step(0, I_LDR, 4'b0000, 1, F1, VF1M, "long_wait_done");
        step(0, I_LDR, 4'b0000, 0, DEC, V0, "long_wait_dec");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
